// File: rtl/fu_core.sv
// fu_core: registered functional unit with valid/ready request handshake.
// Single-cycle ALU ops return one cycle after acceptance; an optional iterative
// shift-add multiplier (op 0x0C) is built only when FU_MUL_EN is defined.
// Without FU_MUL_EN, op 0x0C behaves as an undefined opcode and in_ready is tied high.
module fu_core #(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  data_a,
  input  logic [DSIZE-1:0]  data_b,
  output logic              out_valid,
  output logic [DSIZE-1:0]  F_o,
  output logic              Z_o,
  output logic              N_o,
  output logic              C_o,
  output logic              V_o
);

  localparam logic [OPSIZE-1:0] OP_PASS = OPSIZE'(8'h00);
  localparam logic [OPSIZE-1:0] OP_ADD  = OPSIZE'(8'h01);
  localparam logic [OPSIZE-1:0] OP_SUB  = OPSIZE'(8'h02);
  localparam logic [OPSIZE-1:0] OP_AND  = OPSIZE'(8'h03);
  localparam logic [OPSIZE-1:0] OP_OR   = OPSIZE'(8'h04);
  localparam logic [OPSIZE-1:0] OP_XOR  = OPSIZE'(8'h05);
  localparam logic [OPSIZE-1:0] OP_NOT  = OPSIZE'(8'h06);
  localparam logic [OPSIZE-1:0] OP_SHL  = OPSIZE'(8'h07);
  localparam logic [OPSIZE-1:0] OP_SHR  = OPSIZE'(8'h08);
  localparam logic [OPSIZE-1:0] OP_ASR  = OPSIZE'(8'h09);
  localparam logic [OPSIZE-1:0] OP_INC  = OPSIZE'(8'h0A);
  localparam logic [OPSIZE-1:0] OP_DEC  = OPSIZE'(8'h0B);

  // Add or subtract on a DSIZE+1-bit intermediate; returns {carry/borrow, overflow, result}.
  function automatic logic [DSIZE+1:0] add_sub(input logic [DSIZE-1:0] a,
                                                input logic [DSIZE-1:0] b,
                                                input logic             sub);
    logic [DSIZE:0] r;
    logic           v;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b};
      v = (a[DSIZE-1] != b[DSIZE-1]) && (r[DSIZE-1] != a[DSIZE-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b};
      v = (a[DSIZE-1] == b[DSIZE-1]) && (r[DSIZE-1] != a[DSIZE-1]);
    end
    return {r[DSIZE], v, r[DSIZE-1:0]};
  endfunction

  logic [DSIZE-1:0]  alu_f;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        shamt;
  logic [DSIZE:0]    shl_w;
  logic [DSIZE:0]    shr_w;
  logic signed [DSIZE:0] asr_w;

  logic              res_load;
  logic [DSIZE-1:0]  res_f;
  logic              res_c;
  logic              res_v;

  logic              out_valid_q;
  logic [DSIZE-1:0]  F_q;
  logic              Z_q, N_q, C_q, V_q;

  // The extra bit in each shift word captures the last bit shifted out
  // (stays 0 for a zero shift amount).
  assign shamt = data_b[3:0];
  assign shl_w = {1'b0, data_a} << shamt;
  assign shr_w = {data_a, 1'b0} >> shamt;
  assign asr_w = $signed({data_a, 1'b0}) >>> shamt;

  // Single-cycle ALU: result plus carry and overflow for the presented opcode.
  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_PASS: alu_f = data_a;
      OP_ADD:  {alu_c, alu_v, alu_f} = add_sub(data_a, data_b, 1'b0);
      OP_SUB:  {alu_c, alu_v, alu_f} = add_sub(data_a, data_b, 1'b1);
      OP_AND:  alu_f = data_a & data_b;
      OP_OR:   alu_f = data_a | data_b;
      OP_XOR:  alu_f = data_a ^ data_b;
      OP_NOT:  alu_f = ~data_a;
      OP_SHL: begin
        alu_f = shl_w[DSIZE-1:0];
        alu_c = shl_w[DSIZE];
      end
      OP_SHR: begin
        alu_f = shr_w[DSIZE:1];
        alu_c = shr_w[0];
      end
      OP_ASR: begin
        alu_f = asr_w[DSIZE:1];
        alu_c = asr_w[0];
      end
      OP_INC:  {alu_c, alu_v, alu_f} = add_sub(data_a, DSIZE'(1), 1'b0);
      OP_DEC:  {alu_c, alu_v, alu_f} = add_sub(data_a, DSIZE'(1), 1'b1);
      default: alu_f = '0;
    endcase
  end

`ifdef FU_MUL_EN
  localparam logic [OPSIZE-1:0] OP_MUL = OPSIZE'(8'h0C);
  localparam int CW = $clog2(DSIZE);

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_start;
  logic               mul_done;
  logic [2*DSIZE-1:0] acc_q;
  logic [2*DSIZE-1:0] mcand_q;
  logic [DSIZE-1:0]   mplier_q;
  logic [2*DSIZE-1:0] acc_step;
  logic               mul_hi_nz;

  // One shift-add step: accumulate the aligned multiplicand when the current multiplier bit is set.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_hi_nz = |acc_step[2*DSIZE-1:DSIZE];
  assign in_ready  = (state_q == S_IDLE);

  // Next-state logic: start a multiply from IDLE, finish on the step where the count reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && (op == OP_MUL)) begin
          state_d   = S_MUL_BUSY;
          cnt_d     = CW'(DSIZE - 1);
          mul_start = 1'b1;
        end
      end
      S_MUL_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          mul_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and step counter; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier datapath: operands loaded on acceptance, shifted once per busy cycle.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= {{DSIZE{1'b0}}, data_a};
      mplier_q <= data_b;
    end else if (state_q == S_MUL_BUSY) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Result select: a finishing multiply, or an accepted single-cycle op.
  always_comb begin
    res_load = 1'b0;
    res_f    = alu_f;
    res_c    = alu_c;
    res_v    = alu_v;
    if (mul_done) begin
      res_load = 1'b1;
      res_f    = acc_step[DSIZE-1:0];
      res_c    = mul_hi_nz;
      res_v    = mul_hi_nz;
    end else if (in_valid && in_ready && (op != OP_MUL)) begin
      res_load = 1'b1;
    end
  end
`else
  assign in_ready = 1'b1;

  // Result select: every presented request is a single-cycle op.
  always_comb begin
    res_load = in_valid;
    res_f    = alu_f;
    res_c    = alu_c;
    res_v    = alu_v;
  end
`endif

  // Output registers: update on a new result, otherwise hold; out_valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      F_q         <= '0;
      Z_q         <= 1'b0;
      N_q         <= 1'b0;
      C_q         <= 1'b0;
      V_q         <= 1'b0;
    end else begin
      out_valid_q <= res_load;
      if (res_load) begin
        F_q <= res_f;
        Z_q <= (res_f == '0);
        N_q <= res_f[DSIZE-1];
        C_q <= res_c;
        V_q <= res_v;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign F_o       = F_q;
  assign Z_o       = Z_q;
  assign N_o       = N_q;
  assign C_o       = C_q;
  assign V_o       = V_q;

endmodule

// File: tb/tb_fu_core.sv
// Testbench for fu_core: directed corner vectors, randomized ops against a
// behavioural reference model, reset behaviour, and (with FU_MUL_EN) the multiplier handshake.
module tb_fu_core;

  localparam int D = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic [D-1:0]  data_a;
  logic [D-1:0]  data_b;
  logic          out_valid;
  logic [D-1:0]  F_o;
  logic          Z_o, N_o, C_o, V_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [D+3:0] last_exp;

  fu_core #(.DSIZE(D), .OPSIZE(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data_a(data_a), .data_b(data_b), .out_valid(out_valid),
    .F_o(F_o), .Z_o(Z_o), .N_o(N_o), .C_o(C_o), .V_o(V_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the opcode rules using plain integer arithmetic.
  // Returns {F, Z, N, C, V}.
  function automatic logic [D+3:0] model(input logic [4:0] o, input logic [D-1:0] a,
                                         input logic [D-1:0] b);
    int ua, ub, sa, sb, r, sr, s;
    longint p;
    logic c, v;
    logic [D-1:0] f;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    s = b[3:0]; r = 0; sr = 0; c = 1'b0; v = 1'b0; p = 0;
    case (o)
      5'h00: r = ua;
      5'h01: begin r = ua + ub; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      5'h02: begin r = ua - ub; c = (ua < ub);   sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      5'h03: r = ua & ub;
      5'h04: r = ua | ub;
      5'h05: r = ua ^ ub;
      5'h06: r = ~ua;
      5'h07: begin r = ua << s; c = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
      5'h08: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      5'h09: begin r = sa >>> s; c = (s != 0) && (((sa >>> (s - 1)) & 1) == 1); end
      5'h0A: begin r = ua + 1; c = (ua == 65535); sr = sa + 1; v = (sr > 32767); end
      5'h0B: begin r = ua - 1; c = (ua == 0);     sr = sa - 1; v = (sr < -32768); end
`ifdef FU_MUL_EN
      5'h0C: begin
        p = longint'(ua) * longint'(ub);
        r = int'(p & 64'hFFFF);
        c = ((p >> 16) != 0);
        v = c;
      end
`endif
      default: r = 0;
    endcase
    f = r[D-1:0];
    return {f, (f == 0), f[D-1], c, v};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = '0; data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b F=%h ZNCV=%b%b%b%b rdy=%b, want ov=0 F=0000 ZNCV=0000 rdy=1",
               out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready);
    end
    rst_n = 1'b1;
    // A few ops, then reset asserted mid-stream with a request on the bus.
    op = 5'h01; data_a = 16'h0002; data_b = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 5'h05; data_a = 16'h00F0; data_b = 16'h0FF0;
    #3; rst_n = 1'b0; #1;
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: got ov=%b F=%h ZNCV=%b%b%b%b rdy=%b, want all 0 rdy=1",
               out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, F_o} !== {1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_held: got ov=%b F=%h, want ov=0 F=0000", out_valid, F_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    last_exp = model(op, data_a, data_b);
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b1, last_exp}) begin
      n_fail++;
      $display("FAIL reset_first_op: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=1 F=%h ZNCV=%b",
               out_valid, F_o, Z_o, N_o, C_o, V_o, last_exp[D+3:4], last_exp[3:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [4:0]   o[10];
    logic [D-1:0] a[10];
    logic [D-1:0] b[10];
    logic [D+3:0] e;
    o = '{5'h01, 5'h01, 5'h02, 5'h0B, 5'h07, 5'h09, 5'h1F, 5'h08, 5'h0A, 5'h0B};
    a = '{16'h7FFF, 16'hFFFF, 16'h0003, 16'h8000, 16'h8001, 16'h8000, 16'h1234, 16'h0001, 16'h7FFF, 16'h0000};
    b = '{16'h0001, 16'h0001, 16'h0005, 16'h0000, 16'h0001, 16'h0004, 16'h5678, 16'h0000, 16'h0000, 16'h0000};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      op = o[i]; data_a = a[i]; data_b = b[i]; in_valid = 1'b1;
      e = model(o[i], a[i], b[i]);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%h a=%h b=%h: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=1 F=%h ZNCV=%b",
                 i, o[i], a[i], b[i], out_valid, F_o, Z_o, N_o, C_o, V_o, e[D+3:4], e[3:0]);
      end
      last_exp = e;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [D-1:0] corner[5];
    logic [D-1:0] a, b;
    logic [4:0]   o;
    logic [D+3:0] e;
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int i = 0; i < 200; i++) begin
      o = 5'($urandom_range(0, 31));
`ifdef FU_MUL_EN
      if (o == 5'h0C) o = 5'h02;
`endif
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      op = o; data_a = a; data_b = b; in_valid = 1'b1;
      e = model(o, a, b);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=1 F=%h ZNCV=%b",
                 i, o, a, b, out_valid, F_o, Z_o, N_o, C_o, V_o, e[D+3:4], e[3:0]);
      end
      last_exp = e;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      op = 5'($urandom); data_a = 16'($urandom); data_b = 16'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b0, last_exp}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=0 F=%h ZNCV=%b",
                 i, out_valid, F_o, Z_o, N_o, C_o, V_o, last_exp[D+3:4], last_exp[3:0]);
      end
    end
  endtask

`ifdef FU_MUL_EN
  task automatic test_mul_busy();
    logic [D+3:0] e;
    int bad;
    op = 5'h0C; data_a = 16'h0100; data_b = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    // Next request presented while the multiply runs; it must wait.
    op = 5'h01; data_a = 16'h0005; data_b = 16'h0007;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_busy_window: %0d of 16 cycles had in_ready or out_valid set, want 0", bad);
    end
    @(posedge clk); #1;
    e = model(5'h0C, 16'h0100, 16'h0100);
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready} !== {1'b1, e, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_0100x0100: got ov=%b F=%h ZNCV=%b%b%b%b rdy=%b, want ov=1 F=%h ZNCV=%b rdy=1",
               out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready, e[D+3:4], e[3:0]);
    end
    @(posedge clk); #1;
    e = model(5'h01, 16'h0005, 16'h0007);
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL held_add_after_mul: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=1 F=%h ZNCV=%b",
               out_valid, F_o, Z_o, N_o, C_o, V_o, e[D+3:4], e[3:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mul_values();
    logic [D-1:0] av[3];
    logic [D-1:0] bv[3];
    logic [D+3:0] e;
    int lat;
    av = '{16'h0003, 16'($urandom), 16'hFFFF};
    bv = '{16'h0005, 16'($urandom), 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      op = 5'h0C; data_a = av[i]; data_b = bv[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (out_valid !== 1'b1 && lat < 40);
      e = model(5'h0C, av[i], bv[i]);
      n_checks++;
      if (lat != 16 || {F_o, Z_o, N_o, C_o, V_o} !== e) begin
        n_fail++;
        $display("FAIL mul[%0d] %h*%h: got lat=%0d F=%h ZNCV=%b%b%b%b, want lat=16 F=%h ZNCV=%b",
                 i, av[i], bv[i], lat, F_o, Z_o, N_o, C_o, V_o, e[D+3:4], e[3:0]);
      end
    end
  endtask

  task automatic test_mul_reset();
    logic [D+3:0] e;
    int seen;
    op = 5'h0C; data_a = 16'h1234; data_b = 16'h0042; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_reset_abort: got rdy=%b ov=%b, want rdy=1 ov=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_reset_no_result: got %0d out_valid pulses rdy=%b, want 0 pulses rdy=1", seen, in_ready);
    end
    op = 5'h02; data_a = 16'h0003; data_b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    e = model(5'h02, 16'h0003, 16'h0005);
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL mul_reset_next_op: got ov=%b F=%h ZNCV=%b%b%b%b, want ov=1 F=%h ZNCV=%b",
               out_valid, F_o, Z_o, N_o, C_o, V_o, e[D+3:4], e[3:0]);
    end
    in_valid = 1'b0;
  endtask
`else
  task automatic test_op0c();
    op = 5'h0C; data_a = 16'h0003; data_b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready} !== {1'b1, 16'h0000, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL op0c_undefined: got ov=%b F=%h ZNCV=%b%b%b%b rdy=%b, want ov=1 F=0000 ZNCV=1000 rdy=1",
               out_valid, F_o, Z_o, N_o, C_o, V_o, in_ready);
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
`ifdef FU_MUL_EN
    test_mul_busy();
    test_mul_values();
    test_mul_reset();
`else
    test_op0c();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
